// File: rtl/imm_gen_pkg.sv
// Shared types and constants for the decode-stage immediate generator.
package imm_gen_pkg;

    localparam int unsigned IMM_XLEN = 32;
    localparam int unsigned OPC_W    = 7;

    typedef enum logic [2:0] {
        IMM_R,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_SHAMT
    } imm_format_e;

    // Occupancy encoding: bit 0 is main_valid, bit 1 is skid_valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } stage_state_e;

    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_FENCE  = 7'b0001111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [IMM_XLEN-1:0] imm;
        imm_format_e         fmt;
        logic                illegal;
    } imm_entry_t;

endpackage

// File: rtl/imm_gen_stage_imm_decode.sv
// Combinational RV32I format classifier and immediate extractor.
module imm_decode
    import imm_gen_pkg::*;
(
    input  logic [IMM_XLEN-1:0] instr,
    output imm_entry_t          entry_c
);

    logic [OPC_W-1:0] opcode;
    logic [2:0]       funct3;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    always_comb begin
        entry_c.imm     = '0;
        entry_c.fmt     = IMM_R;
        entry_c.illegal = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                entry_c.imm = {instr[31:12], 12'b0};
                entry_c.fmt = IMM_U;
            end
            OPC_JAL: begin
                entry_c.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                               instr[30:21], 1'b0};
                entry_c.fmt = IMM_J;
            end
            OPC_JALR, OPC_LOAD, OPC_FENCE, OPC_SYSTEM: begin
                entry_c.imm = {{20{instr[31]}}, instr[31:20]};
                entry_c.fmt = IMM_I;
            end
            OPC_OP_IMM: begin
                // Shift-immediates carry a 5-bit zero-extended shamt, not a signed imm.
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    entry_c.imm = {27'b0, instr[24:20]};
                    entry_c.fmt = IMM_SHAMT;
                end else begin
                    entry_c.imm = {{20{instr[31]}}, instr[31:20]};
                    entry_c.fmt = IMM_I;
                end
            end
            OPC_STORE: begin
                entry_c.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                entry_c.fmt = IMM_S;
            end
            OPC_BRANCH: begin
                entry_c.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                               instr[11:8], 1'b0};
                entry_c.fmt = IMM_B;
            end
            OPC_OP: begin
                entry_c.fmt = IMM_R;
            end
            default: begin
                entry_c.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator with a registered output and a one-entry skid,
// so instr_ready depends only on local state.
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = IMM_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [XLEN-1:0] instruction,
    input  logic            flush,
    output logic            imm_valid,
    input  logic            imm_ready,
    output logic [XLEN-1:0] immediate_data,
    output logic [2:0]      imm_format,
    output logic            illegal
);

    stage_state_e state_q, state_d;
    imm_entry_t   main_q, main_d;
    imm_entry_t   skid_q, skid_d;
    imm_entry_t   dec_entry;
    logic [XLEN-1:0] instr_gated;
    logic         in_xfer;
    logic         out_xfer;

    // Keep an idle (possibly X) bus out of the decoder.
    assign instr_gated = instr_valid ? instruction : '0;

    imm_decode u_imm_decode (
        .instr   (instr_gated),
        .entry_c (dec_entry)
    );

    assign instr_ready    = ~state_q[1];
    assign imm_valid      = state_q[0];
    assign immediate_data = main_q.imm;
    assign imm_format     = main_q.fmt;
    assign illegal        = main_q.illegal;

    // A flushed cycle never admits a word.
    assign in_xfer  = instr_valid & instr_ready & ~flush;
    assign out_xfer = imm_valid & imm_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    main_d  = dec_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (out_xfer && in_xfer) begin
                    main_d = dec_entry;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end else if (in_xfer) begin
                    skid_d  = dec_entry;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '{imm: '0, fmt: IMM_R, illegal: 1'b0};
            skid_q  <= '{imm: '0, fmt: IMM_R, illegal: 1'b0};
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage: driver queues hand-computed results, monitor checks outputs.
module tb_imm_gen_stage;
    import imm_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instruction = '0;
    logic        flush = 1'b0;
    logic        imm_valid;
    logic        imm_ready = 1'b0;
    logic [31:0] immediate_data;
    logic [2:0]  imm_format;
    logic        illegal;

    int errors = 0;
    int checks = 0;
    imm_entry_t sb[$];

    imm_gen_stage #(.XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .flush          (flush),
        .imm_valid      (imm_valid),
        .imm_ready      (imm_ready),
        .immediate_data (immediate_data),
        .imm_format     (imm_format),
        .illegal        (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic imm_entry_t ent(input logic [31:0] imm, input imm_format_e fmt,
                                       input logic ill);
        imm_entry_t e;
        e.imm = imm;
        e.fmt = fmt;
        e.illegal = ill;
        return e;
    endfunction

    // Monitor: every output transfer must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && imm_valid && imm_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", immediate_data, 32'hDEAD_BEEF);
            end else begin
                imm_entry_t e;
                e = sb.pop_front();
                chk("immediate_data", immediate_data, e.imm);
                chk("imm_format", 32'(imm_format), 32'(e.fmt));
                chk("illegal", 32'(illegal), 32'(e.illegal));
            end
        end
    end

    task automatic send(input logic [31:0] w, input imm_entry_t e);
        instr_valid = 1'b1;
        instruction = w;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (instr_ready && !flush) begin
                sb.push_back(e);
                @(posedge clk);
                #1;
                instr_valid = 1'b0;
                instruction = 'x;
                return;
            end
            @(posedge clk);
            #1;
        end
        chk("send_timeout", 32'd0, 32'd1);
        instr_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && sb.size() != 0; n++) @(posedge clk);
        #1;
        chk("queue_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_imm_valid", 32'(imm_valid), 32'd0);
        chk("rst_immediate_data", immediate_data, 32'd0);
        chk("rst_imm_format", 32'(imm_format), 32'(IMM_R));
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_instr_ready", 32'(instr_ready), 32'd1);

        // Single ADDI with one-cycle latency
        @(posedge clk); #1;
        imm_ready = 1'b1;
        send(32'hFFF0_0093, ent(32'hFFFF_FFFF, IMM_I, 1'b0));
        chk("latency_imm_valid", 32'(imm_valid), 32'd1);
        drain();

        // Back-to-back format sweep
        send(32'h0011_2623, ent(32'h0000_000C, IMM_S, 1'b0));
        send(32'hFE00_0EE3, ent(32'hFFFF_FFFC, IMM_B, 1'b0));
        send(32'h1234_52B7, ent(32'h1234_5000, IMM_U, 1'b0));
        send(32'h4030_D093, ent(32'h0000_0003, IMM_SHAMT, 1'b0));
        send(32'h0000_0033, ent(32'h0000_0000, IMM_R, 1'b0));
        send(32'h8000_006F, ent(32'hFFF0_0000, IMM_J, 1'b0));
        drain();

        // Illegal opcode
        send(32'h0000_007F, ent(32'h0000_0000, IMM_R, 1'b1));
        drain();

        // Backpressure: A and B held, C stalls upstream
        imm_ready = 1'b0;
        send(32'h0010_0093, ent(32'h0000_0001, IMM_I, 1'b0));
        send(32'h0020_0093, ent(32'h0000_0002, IMM_I, 1'b0));
        instr_valid = 1'b1;
        instruction = 32'h0030_0093;
        repeat (3) begin
            @(negedge clk);
            chk("full_instr_ready", 32'(instr_ready), 32'd0);
            chk("full_imm_valid", 32'(imm_valid), 32'd1);
        end
        @(posedge clk); #1;
        imm_ready = 1'b1;
        send(32'h0030_0093, ent(32'h0000_0003, IMM_I, 1'b0));
        drain();

        // Flush while FULL with a simultaneous input word
        imm_ready = 1'b0;
        send(32'h0040_0093, ent(32'h0000_0004, IMM_I, 1'b0));
        send(32'h0050_0093, ent(32'h0000_0005, IMM_I, 1'b0));
        instr_valid = 1'b1;
        instruction = 32'h0060_0093;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        instr_valid = 1'b0;
        sb.delete();
        chk("flush_imm_valid", 32'(imm_valid), 32'd0);
        chk("flush_instr_ready", 32'(instr_ready), 32'd1);
        imm_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Asynchronous reset while FULL
        imm_ready = 1'b0;
        send(32'h0070_0093, ent(32'h0000_0007, IMM_I, 1'b0));
        send(32'h0080_0093, ent(32'h0000_0008, IMM_I, 1'b0));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("areset_imm_valid", 32'(imm_valid), 32'd0);
        chk("areset_instr_ready", 32'(instr_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        imm_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_imm_valid", 32'(imm_valid), 32'd0);
        chk("post_reset_instr_ready", 32'(instr_ready), 32'd1);
        chk("post_reset_data", immediate_data, 32'd0);

        // Stream resumes cleanly after reset
        send(32'hFFF0_0093, ent(32'hFFFF_FFFF, IMM_I, 1'b0));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
